pio_bank: RTL and testbench
===========================

# pio_bank

Parametrised memory-mapped parallel I/O bank for the Nios system. It replaces the fixed-width button, switch and LED exports with one Avalon-MM slave. The slave provides:
- synchronised and debounced inputs,
- per-bit edge capture with selectable polarity,
- a maskable level interrupt,
- an output register with atomic set/clear access.

One instance serves buttons, switches or LEDs. Width and debounce time are set per instance.

## Interface
- IN_WIDTH, 4: number of input channels, 1..32.
- OUT_WIDTH, 8: number of output bits, 1..32.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required before an input change is accepted, ≥1.

Ports:
- clk_clk  in  1  system clock; all logic is on its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high level.
- pio_in  in  IN_WIDTH  raw asynchronous inputs.
- pio_out  out  OUT_WIDTH  output register contents.

## Operation
- Input path, per channel:
  - 2-flop synchroniser feeds a debounce counter.
  - While the synchronised value equals the stable value, the counter is 0.
  - While it differs, the counter increments each cycle.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter clears.
  - Any return to the stable value before that clears the counter; no update occurs.
- Edge capture:
  - Registered in the same cycle the stable value updates.
  - EDGE_SEL bit 0 captures a 0→1 update; bit 1 captures a 1→0 update.
- Register map; bits above the field width read 0 and ignore writes:
  - 0 DATA_IN, RO: stable input values.
  - 1 DATA_OUT, RW: drives pio_out.
  - 2 IRQ_MASK, RW.
  - 3 EDGE_CAP, write-1-to-clear.
  - 4 EDGE_SEL, RW.
  - 5 OUT_SET, WO: DATA_OUT |= writedata.
  - 6 OUT_CLR, WO: DATA_OUT &= ~writedata.
  - 7 INFO, RO: {8'd0, DEBOUNCE_CYCLES[15:0] saturated to 16'hFFFF, OUT_WIDTH[5:0]-1 in [7:2]?}. This is not used: INFO reads {16'd0, 2'd0, OUT_WIDTH[5:0], 2'd0, IN_WIDTH[5:0]}.
- WO registers read 0.
- irq = |(EDGE_CAP & IRQ_MASK), driven combinationally from registers.
- Simultaneous capture event and W1C write on the same bit: the bit stays 1 (event wins). Other bits clear normally.
- Simultaneous read and write: both take effect. Read data reflects register contents before the write.
- Changing EDGE_SEL does not set or clear EDGE_CAP bits.
- Counter width is clog2(DEBOUNCE_CYCLES+1). No wrap-around is possible.
- Reset, asynchronous, mid-debounce or mid-transfer:
  - Synchronisers, stable values, counters, DATA_OUT, IRQ_MASK, EDGE_CAP, EDGE_SEL, readdata and irq all go to 0. pio_out therefore goes to 0.
  - Any pending read returns no data.
  - After reset release, an input held at 1 produces a rising capture once debounced.

## Timing
- Read latency is 1 cycle; readdata is valid the cycle after read is high. readdata holds its last value otherwise. There is no waitrequest.
- Write takes effect at the clock edge where write is high. pio_out and irq reflect it from that edge.
- Input latency: a pio_in change held steady updates DATA_IN, and sets EDGE_CAP/irq, at edge 2 + DEBOUNCE_CYCLES after the first sampling edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.

## Test plan
- Reset: drive all ports random, then pulse reset_reset for 3 cycles → pio_out=0, irq=0, all register reads return 0 except INFO (IN_WIDTH=4, OUT_WIDTH=8 → 0x0000_0804).
- Output access: write DATA_OUT=0xA5, OUT_SET=0x0F, OUT_CLR=0x81 → pio_out 0xA5 → 0xAF → 0x2E. DATA_OUT read returns 0x2E one cycle after read.
- Debounce, DEBOUNCE_CYCLES=8:
  - pio_in[0] high for 5 cycles, then low → DATA_IN stays 0, EDGE_CAP stays 0.
  - Held high → DATA_IN[0]=1 exactly 10 edges after first sample, EDGE_CAP[0]=1.
- Edge polarity and IRQ: EDGE_SEL=0x2, IRQ_MASK=0x3. Bit 1 goes 0→1 then 1→0, and bit 0 goes 0→1 → EDGE_CAP=0x3 and irq=1. Write EDGE_CAP=0x1 → EDGE_CAP=0x2, irq stays 1. Write 0x2 → irq=0.
- Collision: a bit 0 capture lands on the same edge as a write EDGE_CAP=0x1 → EDGE_CAP[0]=1, irq remains asserted.
- Reset mid-operation: assert reset_reset during a debounce count at 6/8 with DATA_OUT=0xFF → pio_out=0 asynchronously, before the next clock edge. After release with the input still high → rising capture after 2+8 edges.

Source files
------------

// File: rtl/pio_bank.sv
// Memory-mapped parallel I/O bank: debounced inputs with edge capture and a
// maskable level irq, plus an output register with atomic set/clear.

module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_upd;

  // Accept on the cycle the count would reach DEBOUNCE_CYCLES
  assign w_upd = (r_s2 != r_stable) && (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_upd) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_upd & r_s2;
  assign o_fall   = w_upd & ~r_s2;
endmodule

module pio_bank #(
  parameter int IN_WIDTH        = 4,
  parameter int OUT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out
);
  localparam logic [5:0] IW6 = 6'(IN_WIDTH);
  localparam logic [5:0] OW6 = 6'(OUT_WIDTH);

  logic [IN_WIDTH-1:0]  w_stable, w_rise, w_fall, w_evt, w_clr;
  logic [OUT_WIDTH-1:0] r_data_out;
  logic [IN_WIDTH-1:0]  r_mask, r_cap, r_sel;
  logic [31:0]          r_readdata, w_rdata;
  logic                 w_unused;

  pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [IN_WIDTH-1:0] (
    .i_clk    (clk_clk),
    .i_rst    (reset_reset),
    .i_raw    (pio_in),
    .o_stable (w_stable),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // EDGE_SEL bit = 0 selects rising, 1 selects falling, per channel
  assign w_evt = (w_rise & ~r_sel) | (w_fall & r_sel);
  assign w_clr = (write && address == 3'd3) ? writedata[IN_WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      3'd0: w_rdata = 32'(w_stable);
      3'd1: w_rdata = 32'(r_data_out);
      3'd2: w_rdata = 32'(r_mask);
      3'd3: w_rdata = 32'(r_cap);
      3'd4: w_rdata = 32'(r_sel);
      3'd7: w_rdata = {16'd0, 2'd0, OW6, 2'd0, IW6};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_data_out <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_sel      <= '0;
      r_readdata <= '0;
    end else begin
      if (read) r_readdata <= w_rdata;
      // Capture event wins over a same-cycle W1C on that bit
      r_cap <= (r_cap & ~w_clr) | w_evt;
      if (write) begin
        case (address)
          3'd1: r_data_out <= writedata[OUT_WIDTH-1:0];
          3'd2: r_mask     <= writedata[IN_WIDTH-1:0];
          3'd4: r_sel      <= writedata[IN_WIDTH-1:0];
          3'd5: r_data_out <= r_data_out | writedata[OUT_WIDTH-1:0];
          3'd6: r_data_out <= r_data_out & ~writedata[OUT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign w_unused = &{1'b0, writedata};
  assign readdata = r_readdata;
  assign pio_out  = r_data_out;
  assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_pio_bank.sv
// Directed bench for pio_bank (DEBOUNCE_CYCLES=8): read results are queued
// as expectations when the read is issued and checked when readdata lands.

module tb_pio_bank;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  pio_in = '0;
  logic [7:0]  pio_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  pio_bank #(.IN_WIDTH(4), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(8)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .pio_in      (pio_in),
    .pio_out     (pio_out)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk_clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk_clk);
    address = a; read = 1'b1;
    sb.push_back(exp);
    @(posedge clk_clk); #1;
    read = 1'b0;
    chk(tag, readdata, sb.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  initial begin
    // Random activity on every input, then a 3-cycle reset
    repeat (3) begin
      @(negedge clk_clk);
      address = 3'($urandom); read = 1'($urandom); write = 1'($urandom);
      writedata = $urandom; pio_in = 4'($urandom);
    end
    @(negedge clk_clk);
    reset_reset = 1'b1;
    repeat (2) @(negedge clk_clk);
    read = 1'b0; write = 1'b0; pio_in = '0;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    chk("rst_pio_out", 32'(pio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 7; i++) rd(3'(i), 32'h0, $sformatf("rst_reg%0d", i));
    rd(3'd7, 32'h0000_0804, "info");

    // Output register access
    wr(3'd1, 32'hA5);
    chk("out_write", 32'(pio_out), 32'hA5);
    wr(3'd5, 32'h0F);
    chk("out_set", 32'(pio_out), 32'hAF);
    wr(3'd6, 32'h81);
    chk("out_clr", 32'(pio_out), 32'h2E);
    rd(3'd1, 32'h2E, "out_read");
    rd(3'd5, 32'h0, "set_reads0");
    wr(3'd1, 32'hFFFF_FF00);
    chk("out_upper_ignored", 32'(pio_out), 32'h0);

    // Glitch shorter than the debounce time
    @(negedge clk_clk); pio_in[0] = 1'b1;
    repeat (5) @(posedge clk_clk);
    @(negedge clk_clk); pio_in[0] = 1'b0;
    idle(20);
    rd(3'd0, 32'h0, "glitch_datain");
    rd(3'd3, 32'h0, "glitch_cap");

    // Held input: accepted on edge 10 counting the first sampling edge
    wr(3'd2, 32'h1);
    @(negedge clk_clk); pio_in[0] = 1'b1;
    repeat (9) @(posedge clk_clk);
    #1 chk("db_edge9_irq", 32'(irq), 32'h0);
    @(posedge clk_clk);
    #1 chk("db_edge10_irq", 32'(irq), 32'h1);
    rd(3'd0, 32'h1, "db_datain");
    rd(3'd3, 32'h1, "db_cap");
    wr(3'd3, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);

    // Polarity select and masking
    wr(3'd4, 32'h2);
    wr(3'd2, 32'h3);
    @(negedge clk_clk); pio_in[0] = 1'b0;
    idle(15);
    @(negedge clk_clk); pio_in[1] = 1'b1;
    idle(15);
    rd(3'd3, 32'h0, "pol_no_capture");
    rd(3'd4, 32'h2, "edgesel_read");
    @(negedge clk_clk); pio_in[1] = 1'b0;
    idle(15);
    @(negedge clk_clk); pio_in[0] = 1'b1;
    idle(15);
    rd(3'd3, 32'h3, "pol_cap");
    chk("pol_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h2, "pol_clr0");
    chk("pol_irq_held", 32'(irq), 32'h1);
    wr(3'd3, 32'h2);
    chk("pol_irq_clr", 32'(irq), 32'h0);

    // Capture and W1C on the same edge: capture wins
    @(negedge clk_clk); pio_in[0] = 1'b0;
    idle(15);
    @(negedge clk_clk); pio_in[0] = 1'b1;
    repeat (9) @(posedge clk_clk);
    @(negedge clk_clk);
    address = 3'd3; writedata = 32'h1; write = 1'b1;
    @(posedge clk_clk); #1;
    write = 1'b0;
    chk("coll_irq", 32'(irq), 32'h1);
    rd(3'd3, 32'h1, "coll_cap");
    wr(3'd3, 32'h1);
    chk("coll_clr_irq", 32'(irq), 32'h0);

    // Asynchronous reset part-way through a debounce count
    wr(3'd1, 32'hFF);
    chk("pre_rst_out", 32'(pio_out), 32'hFF);
    @(negedge clk_clk); pio_in[0] = 1'b0;
    idle(15);
    @(negedge clk_clk); pio_in[0] = 1'b1;
    repeat (8) @(posedge clk_clk);
    #2 reset_reset = 1'b1;
    #1 chk("async_rst_out", 32'(pio_out), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk_clk);
    address = 3'd2; writedata = 32'h1; write = 1'b1;
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    write = 1'b0;
    repeat (8) @(posedge clk_clk);
    #1 chk("rel_edge9_irq", 32'(irq), 32'h0);
    @(posedge clk_clk);
    #1 chk("rel_edge10_irq", 32'(irq), 32'h1);
    chk("rel_pio_out", 32'(pio_out), 32'h0);
    rd(3'd0, 32'h1, "rel_datain");
    rd(3'd4, 32'h0, "rel_edgesel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
